// File: rtl/fp_to_int_seq.sv
// fp_to_int_seq: iterative IEEE-754 single -> signed int32 converter, round to nearest even.
// Mantissa is aligned by at most SHIFT_STEP bits per cycle; start/done handshake.
//
// state | meaning
// IDLE  | waiting for start (ignored while done is high)
// LOAD  | decode captured operand; resolve specials or set up shift
// SHIFT | align mantissa, collecting guard/sticky on right shifts
// ROUND | round to nearest even, apply sign, write result and flags

module fp_to_int_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    ROUND = 2'd3
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state, state_nxt;
  logic [31:0] op_q, op_nxt;
  logic [31:0] wreg, wreg_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        right, right_nxt;
  logic        guard, guard_nxt;
  logic        sticky, sticky_nxt;
  logic [31:0] result_nxt;
  logic        invalid_nxt;
  logic        inexact_nxt;
  logic        done_nxt;

  logic        op_s;
  logic [7:0]  op_e;
  logic [22:0] op_f;
  logic [31:0] sat;
  logic [4:0]  k;
  logic        lost;
  logic        g_out;
  logic [31:0] mag;

  assign op_s = op_q[31];
  assign op_e = op_q[30:23];
  assign op_f = op_q[22:0];
  assign sat  = op_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
  assign busy = (state != IDLE) | done;

  // Per-cycle shift amount and the bits it drops (right shift only uses these)
  always_comb begin
    k     = (cnt < STEP) ? cnt : STEP;
    lost  = 1'b0;
    g_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (5'(i) + 5'd1 < k)  lost  = lost | wreg[i];
      if (5'(i) + 5'd1 == k) g_out = wreg[i];
    end
  end

  assign mag = wreg + {31'd0, guard & (sticky | wreg[0])};

  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    wreg_nxt    = wreg;
    cnt_nxt     = cnt;
    right_nxt   = right;
    guard_nxt   = guard;
    sticky_nxt  = sticky;
    result_nxt  = result;
    invalid_nxt = invalid;
    inexact_nxt = inexact;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start && !done) begin
          op_nxt    = operand;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        state_nxt  = IDLE;
        guard_nxt  = 1'b0;
        sticky_nxt = 1'b0;
        wreg_nxt   = {8'd0, 1'b1, op_f};
        if (op_e == 8'd255) begin
          result_nxt  = (op_f != 23'd0) ? 32'd0 : sat;
          invalid_nxt = 1'b1;
          inexact_nxt = 1'b0;
          done_nxt    = 1'b1;
        end else if (op_e == 8'd0) begin
          result_nxt  = 32'd0;
          invalid_nxt = 1'b0;
          inexact_nxt = (op_f != 23'd0);
          done_nxt    = 1'b1;
        end else if (op_e >= 8'd158) begin
          // -2^31 is the only representable value at or beyond this magnitude
          if (op_q == 32'hCF00_0000) begin
            result_nxt  = 32'h8000_0000;
            invalid_nxt = 1'b0;
          end else begin
            result_nxt  = sat;
            invalid_nxt = 1'b1;
          end
          inexact_nxt = 1'b0;
          done_nxt    = 1'b1;
        end else if (op_e >= 8'd150) begin
          right_nxt = 1'b0;
          cnt_nxt   = 5'(op_e - 8'd150);
          state_nxt = (op_e == 8'd150) ? ROUND : SHIFT;
        end else begin
          right_nxt = 1'b1;
          cnt_nxt   = (op_e < 8'd125) ? 5'd25 : 5'(8'd150 - op_e);
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        cnt_nxt = cnt - k;
        if (right) begin
          wreg_nxt   = wreg >> k;
          guard_nxt  = g_out;
          sticky_nxt = sticky | guard | lost;
        end else begin
          wreg_nxt = wreg << k;
        end
        if (cnt == k) state_nxt = ROUND;
      end

      ROUND: begin
        result_nxt  = op_s ? (~mag + 32'd1) : mag;
        inexact_nxt = guard | sticky;
        invalid_nxt = 1'b0;
        done_nxt    = 1'b1;
        state_nxt   = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= 32'd0;
      wreg    <= 32'd0;
      cnt     <= 5'd0;
      right   <= 1'b0;
      guard   <= 1'b0;
      sticky  <= 1'b0;
      result  <= 32'd0;
      invalid <= 1'b0;
      inexact <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      wreg    <= wreg_nxt;
      cnt     <= cnt_nxt;
      right   <= right_nxt;
      guard   <= guard_nxt;
      sticky  <= sticky_nxt;
      result  <= result_nxt;
      invalid <= invalid_nxt;
      inexact <= inexact_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Bench for fp_to_int_seq: four instances (SHIFT_STEP 1,2,4,8) fed the same stimulus,
// directed vectors with hand-computed results plus random operands against an integer model.

module tb_fp_to_int_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] operand;

  logic        busy_w [4];
  logic        done_w [4];
  logic [31:0] res_w  [4];
  logic        inv_w  [4];
  logic        inx_w  [4];

  int lat [4];
  int busy_n, done_n;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fp_to_int_seq #(.SHIFT_STEP(1 << g)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .operand (operand),
      .busy    (busy_w[g]),
      .done    (done_w[g]),
      .result  (res_w[g]),
      .invalid (inv_w[g]),
      .inexact (inx_w[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value scaled by 2^32 in 64-bit fixed point, then round nearest even
  function automatic logic [33:0] model(input logic [31:0] op);
    logic        s, inv, inx, up;
    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] res, ip, fr, mg;
    logic [63:0] fx;
    int          sh;
    s = op[31]; e = op[30:23]; f = op[22:0];
    inv = 1'b0; inx = 1'b0; res = 32'd0;
    if (e == 8'hFF) begin
      inv = 1'b1;
      res = (f != 0) ? 32'd0 : (s ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end else if (e == 8'd0) begin
      inx = (f != 0);
    end else if (int'(e) - 127 >= 31) begin
      if (op == 32'hCF00_0000) res = 32'h8000_0000;
      else begin
        inv = 1'b1;
        res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else begin
      sh = int'(e) - 127 + 9;
      if (sh < 0) begin
        inx = 1'b1;
      end else begin
        fx  = {40'd0, 1'b1, f} << sh;
        ip  = fx[63:32];
        fr  = fx[31:0];
        up  = (fr > 32'h8000_0000) || (fr == 32'h8000_0000 && ip[0]);
        mg  = ip + {31'd0, up};
        inx = (fr != 0);
        res = s ? (~mg + 32'd1) : mg;
      end
    end
    return {inv, inx, res};
  endfunction

  function automatic int lat_exp(input int cnt, input int step);
    return (cnt < 0) ? 2 : 3 + (cnt + step - 1) / step;
  endfunction

  // One conversion; cycle 0 = start cycle. Optionally pokes start (op 5.0) in cycle 'poke'.
  task automatic run_conv(input logic [31:0] op, input int poke, input int extra);
    int cyc;
    bit all;
    for (int k = 0; k < 4; k++) lat[k] = 0;
    @(negedge clk);
    start = 1'b1; operand = op;
    @(negedge clk);
    start = 1'b0; operand = $urandom;
    cyc = 1; busy_n = 0; done_n = 0; all = 1'b0;
    while (1) begin
      if (poke == cyc) begin
        start = 1'b1; operand = 32'h40A0_0000;
      end else begin
        start = 1'b0;
      end
      busy_n += int'(busy_w[0]);
      done_n += int'(done_w[0]);
      all = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (done_w[k] && lat[k] == 0) lat[k] = cyc;
        if (lat[k] == 0) all = 1'b0;
      end
      if (all || cyc >= 60) break;
      @(negedge clk);
      cyc++;
    end
    if (!all) chk("timeout", 64'd0, 64'd1);
    for (int x = 0; x < extra; x++) begin
      @(negedge clk);
      start = 1'b0;
      busy_n += int'(busy_w[0]);
      done_n += int'(done_w[0]);
    end
  endtask

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          cnt;
  } vec_t;

  vec_t vt [15];

  initial begin
    int nd;
    logic [31:0] rop;
    logic [33:0] ex;

    vt[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 23};
    vt[1]  = '{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 22};
    vt[2]  = '{32'hC060_0000, 32'hFFFF_FFFC, 1'b0, 1'b1, 22};
    vt[3]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 24};
    vt[4]  = '{32'h3F00_0001, 32'h0000_0001, 1'b0, 1'b1, 24};
    vt[5]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 7};
    vt[6]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, -1};
    vt[7]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, -1};
    vt[8]  = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 0};
    vt[9]  = '{32'h7FC0_0000, 32'h0000_0000, 1'b1, 1'b0, -1};
    vt[10] = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, -1};
    vt[11] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, -1};
    vt[12] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, -1};
    vt[13] = '{32'h40A0_0000, 32'h0000_0005, 1'b0, 1'b0, 21};
    vt[14] = '{32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b1, 23};

    reset = 1'b1; start = 1'b0; operand = 32'd0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk("reset_out", 64'({busy_w[k], done_w[k], inv_w[k], inx_w[k], res_w[k]}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors
    foreach (vt[i]) begin
      run_conv(vt[i].op, 0, 2);
      for (int k = 0; k < 4; k++) begin
        chk("dir_result", 64'(res_w[k]), 64'(vt[i].res));
        chk("dir_flags", 64'({inv_w[k], inx_w[k]}), 64'({vt[i].inv, vt[i].inx}));
        chk("dir_latency", 64'(lat[k]), 64'(lat_exp(vt[i].cnt, 1 << k)));
      end
      chk("dir_busy_cycles", 64'(busy_n), 64'(lat_exp(vt[i].cnt, 1)));
      chk("dir_done_pulses", 64'(done_n), 64'd1);
    end

    // start while busy is ignored
    run_conv(32'h3F80_0000, 4, 3);
    for (int k = 0; k < 4; k++)
      chk("ign_busy_result", 64'(res_w[k]), 64'd1);
    chk("ign_busy_latency", 64'(lat[0]), 64'd26);
    chk("ign_busy_done_pulses", 64'(done_n), 64'd1);

    // start in the done cycle is ignored
    run_conv(32'h7FC0_0000, 2, 6);
    for (int k = 0; k < 4; k++)
      chk("ign_done_result", 64'({inv_w[k], res_w[k]}), 64'({1'b1, 32'd0}));
    chk("ign_done_busy_cycles", 64'(busy_n), 64'd2);
    chk("ign_done_done_pulses", 64'(done_n), 64'd1);

    // Load a nonzero result, then reset mid-SHIFT
    run_conv(32'h4020_0000, 0, 2);
    @(negedge clk);
    start = 1'b1; operand = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++)
      chk("midreset_out", 64'({busy_w[k], done_w[k], inv_w[k], inx_w[k], res_w[k]}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) nd += int'(done_w[k]);
    end
    chk("midreset_no_done", 64'(nd), 64'd0);
    run_conv(32'hC060_0000, 0, 2);
    for (int k = 0; k < 4; k++)
      chk("post_reset_result", 64'({inv_w[k], inx_w[k], res_w[k]}), 64'({1'b0, 1'b1, 32'hFFFF_FFFC}));

    // Random operands: every step size against the integer model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) < 7)
        rop = {1'($urandom), 8'($urandom_range(110, 160)), 23'($urandom)};
      else
        rop = $urandom;
      ex = model(rop);
      run_conv(rop, 0, 1);
      for (int k = 0; k < 4; k++)
        chk("rand_vs_model", 64'({inv_w[k], inx_w[k], res_w[k]}), 64'(ex));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
